// File: rtl/press_arbiter.sv
// ============================================================================
// press_arbiter : edge-detect N buttons, queue one request each, grant round-robin
// Optional post-grant lockout via `PRESS_ARB_LOCKOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module press_arbiter #(
  parameter int N       = 4,
  parameter int LOCKOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         btn,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [N-1:0]         pending,
  output logic                 busy
);

  localparam int W = $clog2(N);

  if (N < 2 || N > 16 || LOCKOUT < 1 || LOCKOUT > 255) begin : g_param_check
    $error("press_arbiter: parameter out of range");
  end

  logic [N-1:0] btn_q;
  logic [N-1:0] rise;
  logic [N-1:0] pending_next;
  logic [N-1:0] grant_next;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;
  logic [W-1:0] sel;
  logic [W:0]   idx;
  logic         found;
  logic         issue;

  assign rise = btn & ~btn_q;

  // First pending bit at or above ptr, wrapping from N-1 back to 0
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (W+1)'(ptr) + (W+1)'(k);
      if (idx >= (W+1)'(N)) begin
        idx = idx - (W+1)'(N);
      end
      if (!found && pending[idx[W-1:0]]) begin
        found = 1'b1;
        sel   = idx[W-1:0];
      end
    end
  end

`ifdef PRESS_ARB_LOCKOUT_EN
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    issue         = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          issue         = 1'b1;
          state_next    = LOCK;
          lock_cnt_next = 8'(LOCKOUT);
        end
      end
      LOCK: begin
        lock_cnt_next = lock_cnt - 8'd1;
        if (lock_cnt == 8'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == LOCK);
`else
  assign issue = found;
  assign busy  = 1'b0;
`endif

  // A rise on the same edge as its grant survives, so the new press stays queued
  always_comb begin
    grant_next = '0;
    ptr_next   = ptr;
    if (issue) begin
      grant_next[sel] = 1'b1;
      ptr_next        = (sel == W'(N-1)) ? '0 : sel + 1'b1;
    end
    pending_next = (pending & ~grant_next) | rise;
  end

  always_ff @(posedge clk) begin
    btn_q <= btn;
    if (reset) begin
      pending     <= '0;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      pending     <= pending_next;
      ptr         <= ptr_next;
      grant       <= grant_next;
      grant_valid <= issue;
      grant_id    <= issue ? sel : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_press_arbiter.sv
// ============================================================================
// tb_press_arbiter : directed stimulus with a grant scoreboard for press_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_press_arbiter;

  localparam int N  = 4;
  localparam int LK = 3;
`ifdef PRESS_ARB_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif
  localparam int GAP = LOCK_ON ? LK + 1 : 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [N-1:0] pending;
  logic         busy;

  press_arbiter #(.N(N), .LOCKOUT(LK)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_grant(input int id, input int at);
    q.push_back('{id, at});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every visible grant must match the head of the expected queue
  always @(negedge clk) begin
    if (grant_valid || grant != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant actual grant=%b id=%0d cyc=%0d required none",
                 grant, grant_id, cyc);
      end else begin
        e = q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("grant_vec", 32'(grant), 32'(1 << e.id));
        chk("grant_cyc", 32'(cyc), 32'(e.at));
        chk("grant_valid", 32'(grant_valid), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    btn   = '0;
    tick(3);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(2);

    // Simultaneous presses from ptr 0: 0, 1, 3
    c   = cyc;
    btn = 4'b1011;
    expect_grant(0, c + 2);
    expect_grant(1, c + 2 + GAP);
    expect_grant(3, c + 2 + 2 * GAP);
    tick(1);
    chk("sim_pending", 32'(pending), 32'b1011);
    btn = '0;
    tick(14);

    // ptr must be back at 0: 0 before 3
    c   = cyc;
    btn = 4'b1001;
    expect_grant(0, c + 2);
    expect_grant(3, c + 2 + GAP);
    tick(1);
    btn = '0;
    tick(12);

    // Single press held 5 cycles
    c   = cyc;
    btn = 4'b0100;
    expect_grant(2, c + 2);
    tick(1);
    chk("single_pend_set", 32'(pending), 32'b0100);
    tick(1);
    chk("single_pend_clr", 32'(pending), 32'd0);
    tick(3);
    btn = '0;
    tick(8);

    // Lockout spacing: btn[1] pressed one cycle after grant 0
    c   = cyc;
    btn = 4'b0001;
    expect_grant(0, c + 2);
    tick(1);
    btn = '0;
    tick(1);
    btn = 4'b0010;
    expect_grant(1, LOCK_ON ? c + 6 : c + 4);
    chk("lock_busy_a", 32'(busy), 32'(LOCK_ON));
    tick(1);
    btn = '0;
    chk("lock_busy_b", 32'(busy), 32'(LOCK_ON));
    tick(1);
    chk("lock_busy_c", 32'(busy), 32'(LOCK_ON));
    tick(1);
    chk("lock_busy_end", 32'(busy), 32'd0);
    tick(8);

    // Re-press btn[3] twice inside the lockout window
    c   = cyc;
    btn = 4'b0001;
    expect_grant(0, c + 2);
    tick(1);
    btn = '0;
    tick(1);
    if (!LOCK_ON) expect_grant(3, c + 4);
    expect_grant(3, c + 6);
    btn = 4'b1000;
    tick(1);
    btn = '0;
    tick(1);
    btn = 4'b1000;
    tick(1);
    chk("repress_pend3", 32'(pending[3]), 32'd1);
    btn = '0;
    tick(10);

    // Reset mid-LOCK with pending 0110
    c   = cyc;
    btn = 4'b0001;
    expect_grant(0, c + 2);
    tick(1);
    btn = '0;
    tick(1);
    btn = 4'b0110;
    tick(1);
    chk("midlock_pending", 32'(pending), 32'b0110);
    reset = 1'b1;
    btn   = '0;
    tick(1);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_valid", 32'(grant_valid), 32'd0);
    chk("midrst_id", 32'(grant_id), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(10);

    // Button held through reset produces no event until re-pressed
    reset = 1'b1;
    btn   = 4'b0010;
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("held_pending", 32'(pending), 32'd0);
    btn = '0;
    tick(1);
    c   = cyc;
    btn = 4'b0010;
    expect_grant(1, c + 2);
    tick(1);
    btn = '0;
    tick(8);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/press_arbiter.md
# press_arbiter

Shares a single downstream event consumer, such as a score counter or LED shifter, among N push-button requesters. It detects a rising edge on each synchronized button input and queues one pending request per button. Pending requests are granted one at a time in round-robin order, each grant being a single-cycle one-hot pulse. An optional lockout window after each grant throttles the grant rate. The block sits between the input synchronizers and the game/datapath logic on the board.

## Interface
Parameters:
- `N`, default 4: number of requesters; legal range 2..16.
- `LOCKOUT`, default 8: number of idle cycles enforced after each grant; legal range 1..255; used only when the lockout feature is compiled in.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `btn`, input, N: button levels, already synchronized to `clk`.
- `grant`, output, N: one-hot, single-cycle grant pulse.
- `grant_valid`, output, 1: equals `|grant`.
- `grant_id`, output, `$clog2(N)`: index of the granted requester; 0 when `grant_valid` is 0.
- `pending`, output, N: currently queued requests.
- `busy`, output, 1: high while in the LOCK state.

## Operation
- Edge detect:
  - `btn_q` holds the previous cycle's `btn`.
  - `rise[i] = btn[i] & ~btn_q[i]`.
  - During reset, `btn_q` loads `btn`, so a button held through reset produces no event.
- Pending queue:
  - `pending[i]` sets on `rise[i]` and clears on `grant[i]`.
  - If `rise[i]` and the grant of i occur on the same edge, `pending[i]` stays 1: the new press is queued.
  - A rise while `pending[i]` is already 1 is merged; there is no double count.
- Round-robin pointer `ptr`, width `$clog2(N)`, reset value 0:
  - Selection is the first set `pending` bit scanning from `ptr` upward, wrapping from N-1 to 0.
  - After granting index i, `ptr` becomes (i+1) mod N.
- State machine, reset state IDLE:
  - IDLE: if `pending` is nonzero, register the grant of the selected index. The next state is LOCK when lockout is compiled in, otherwise IDLE. If `pending` is zero, stay in IDLE.
  - LOCK: `lock_cnt` loads LOCKOUT on entry and decrements each cycle. No grants are issued. Leave for IDLE when `lock_cnt` reaches 1. Pending bits keep accumulating.
- Reset values:
  - `grant` = 0, `grant_valid` = 0, `grant_id` = 0.
  - `pending` = 0, `busy` = 0, `ptr` = 0, `lock_cnt` = 0.
- Reset asserted mid-LOCK or with requests pending: all state clears on that edge, and queued requests are discarded.

## Timing
- `btn[i]` first sampled high at edge k:
  - `pending[i]` = 1 after edge k.
  - If the block is IDLE, `grant[i]` = 1 during the cycle after edge k+1.
  - `pending[i]` = 0 after edge k+1.
- `grant`, `grant_valid` and `grant_id` are registered outputs, each high for exactly one cycle per grant.
- With lockout compiled in:
  - After a grant at edge g, `busy` is high for cycles g+1 through g+LOCKOUT.
  - The next possible grant is at edge g+LOCKOUT+1.
  - Minimum grant spacing is LOCKOUT+1 cycles.
- With lockout compiled out: grants can be issued on consecutive cycles, and `busy` is held at 0.
- Simultaneous rises on several inputs are all queued on the same edge and granted in round-robin order starting from `ptr`.

## Configuration
- Macro `PRESS_ARB_LOCKOUT_EN`.
- Defined:
  - The LOCK state, `lock_cnt`, and the LOCKOUT parameter are active.
  - `busy` reflects LOCK.
- Undefined:
  - The LOCK state and `lock_cnt` are removed.
  - The FSM remains in IDLE permanently.
  - Grants may be issued back to back, one per cycle.
  - `busy` is tied to 0.

## Test plan
- Single press: raise `btn[2]` for 5 cycles, with N=4 → exactly one `grant` = 0100 with `grant_id` = 2, occurring two edges after the first high sample; `pending` returns to 0.
- Simultaneous presses: raise `btn` = 1011 on one edge, with `ptr` = 0 and lockout off → grants to 0, 1, 3 on three consecutive cycles; `ptr` ends at 0.
- Lockout: with LOCKOUT=3, press `btn[0]`, then press `btn[1]` one cycle after grant 0 → `busy` is high for 3 cycles and `grant[1]` occurs exactly 4 cycles after `grant[0]`.
- Re-press while pending: toggle `btn[3]` twice during LOCK → `pending[3]` stays 1 and a single `grant[3]` is issued.
- Reset mid-LOCK with `pending` = 0110 → all outputs and `pending` are 0 on the next cycle, and no grant follows.
- Held through reset: `btn[1]` = 1 during reset and held afterwards → no grant until `btn[1]` falls and rises again.
